// File: rtl/lc3_mem_bridge_pkg.sv
// lc3_mem_pkg: shared FSM state type and LC-3 memory-mapped I/O addresses for lc3_mem_bridge.
package lc3_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam int KBSR_READY_BIT = 15;
endpackage

// File: rtl/lc3_mem_bridge_if.sv
// lc3_mem_bridge_if: core-side request/ready memory bus of the LC-3 memory bridge.
interface lc3_mem_bridge_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic ld_mar;
    logic mem_en;
    logic mem_we;
    logic mem_rdy;
    logic mem_err;
    modport master (output addr, ld_mar, data_in, mem_en, mem_we, input data_out, mem_rdy, mem_err, mar);
    modport slave (input addr, ld_mar, data_in, mem_en, mem_we, output data_out, mem_rdy, mem_err, mar);
endinterface

// File: rtl/lc3_mem_bridge_sram.sv
// lc3_sram: single-port word store, synchronous write and synchronous read-enabled read, no reset.
module lc3_sram #(
    parameter int DATA_W = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/lc3_mem_bridge.sv
// lc3_mem_bridge: MAR latch, on-chip word store and wait-state sequencer behind a req/ready handshake.
// Define LC3_MMIO_EN to add the keyboard/display registers at 0xFE00-0xFE06 (needs ADDR_W=16).
module lc3_mem_bridge
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic rst_n,
    lc3_mem_bridge_if.slave bus
`ifdef LC3_MMIO_EN
    ,
    input  logic [7:0] kb_data,
    input  logic       kb_strobe,
    output logic [7:0] disp_data,
    output logic       disp_strobe
`endif
);
    state_t state;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] mar_r, acc_addr, cur_addr;
    logic [DATA_W-1:0] acc_wdata, cur_wdata, rd_hold, ram_q, mmio_rd;
    logic acc_we, cur_we, idle, go, in_range, mmio_hit, use_ram, rdy, err;

    // While idle the request is taken straight from the bus so a zero-wait access needs no extra cycle.
    assign idle = state == IDLE;
    assign cur_addr = idle ? (bus.ld_mar ? bus.addr : mar_r) : acc_addr;
    assign cur_wdata = idle ? bus.data_in : acc_wdata;
    assign cur_we = idle ? bus.mem_we : acc_we;
    assign go = idle ? bus.mem_en && (WAIT_STATES == 0) : state == WAIT && cnt == 4'd0;
    assign in_range = (cur_addr >> DEPTH_LOG2) == '0;

    assign bus.mar = mar_r;
    assign bus.mem_rdy = rdy;
    assign bus.mem_err = err;
    assign bus.data_out = use_ram ? ram_q : rd_hold;

    lc3_sram #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clk(clk),
        .we(go && cur_we && in_range),
        .re(go && !cur_we && in_range),
        .addr(cur_addr[DEPTH_LOG2-1:0]),
        .wdata(cur_wdata),
        .rdata(ram_q)
    );

`ifdef LC3_MMIO_EN
    logic kb_ready;
    logic [7:0] kbdr;
    assign mmio_hit = cur_addr inside {KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR};
    assign mmio_rd = cur_addr == KBSR_ADDR ? DATA_W'(kb_ready) << KBSR_READY_BIT :
                     cur_addr == KBDR_ADDR ? DATA_W'(kbdr) :
                     cur_addr == DSR_ADDR  ? DATA_W'(1) << KBSR_READY_BIT : '0;

    // A fresh keystroke wins over the KBDR read that would clear the ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_ready <= 1'b0;
            kbdr <= '0;
            disp_data <= '0;
            disp_strobe <= 1'b0;
        end else begin
            if (kb_strobe) {kb_ready, kbdr} <= {1'b1, kb_data};
            else if (go && !cur_we && cur_addr == KBDR_ADDR) kb_ready <= 1'b0;
            disp_strobe <= go && cur_we && cur_addr == DDR_ADDR;
            if (go && cur_we && cur_addr == DDR_ADDR) disp_data <= cur_wdata[7:0];
        end
    end
`else
    assign mmio_hit = 1'b0;
    assign mmio_rd = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            mar_r <= '0;
            acc_addr <= '0;
            acc_wdata <= '0;
            acc_we <= 1'b0;
            rd_hold <= '0;
            use_ram <= 1'b0;
            rdy <= 1'b0;
            err <= 1'b0;
        end else begin
            if (bus.ld_mar) mar_r <= bus.addr;
            if (idle && bus.mem_en) begin
                acc_addr <= cur_addr;
                acc_wdata <= bus.data_in;
                acc_we <= bus.mem_we;
            end
            cnt <= state == WAIT ? cnt - 4'd1 : 4'(WAIT_STATES - 1);
            state <= go ? XFER : (idle && bus.mem_en) ? WAIT : state == XFER ? IDLE : state;
            rdy <= go;
            err <= go && !in_range && !mmio_hit;
            // Out-of-range reads park zero in rd_hold; the store's own output register holds in-range data.
            if (go && !cur_we) begin
                use_ram <= in_range;
                rd_hold <= mmio_hit ? mmio_rd : '0;
            end
        end
    end
endmodule

// File: tb/tb_lc3_mem_bridge.sv
// tb_lc3_mem_bridge: directed and randomized checks of lc3_mem_bridge against a word-array reference model.
// Covers WAIT_STATES=2 and WAIT_STATES=0 instances; MMIO checks compile in with LC3_MMIO_EN.
module tb_lc3_mem_bridge;
    localparam int WS = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lc3_mem_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus ();
    lc3_mem_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

`ifdef LC3_MMIO_EN
    logic [7:0] kb_data = '0, kb_data0 = '0, disp_data, disp_data0;
    logic kb_strobe = 1'b0, kb_strobe0 = 1'b0, disp_strobe, disp_strobe0;
`endif

    lc3_mem_bridge #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef LC3_MMIO_EN
        , .kb_data(kb_data), .kb_strobe(kb_strobe), .disp_data(disp_data), .disp_strobe(disp_strobe)
`endif
    );

    lc3_mem_bridge #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
`ifdef LC3_MMIO_EN
        , .kb_data(kb_data0), .kb_strobe(kb_strobe0), .disp_data(disp_data0), .disp_strobe(disp_strobe0)
`endif
    );

    logic [15:0] mem_m [0:1023];
    logic [15:0] mar_m = '0, last_rd = '0;
    logic kb_ready_m = 1'b0;
    logic [7:0] kbdr_m = '0;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mmio(input logic [15:0] a);
`ifdef LC3_MMIO_EN
        return a inside {16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06};
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] mmio_read(input logic [15:0] a);
        return a == 16'hFE00 ? {kb_ready_m, 15'h0} : a == 16'hFE02 ? {8'h00, kbdr_m} :
               a == 16'hFE04 ? 16'h8000 : 16'h0000;
    endfunction

    // One complete access on the WAIT_STATES=2 instance, checked against the model.
    task automatic access(input logic ld, input logic we, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] ea, exp;
        logic oob, mm;
        int n;
        if (ld) mar_m = a;
        ea = mar_m;
        mm = is_mmio(ea);
        oob = ea >= 16'd1024 && !mm;
        @(posedge clk); #1;
        bus.addr = a; bus.ld_mar = ld; bus.mem_en = 1'b1; bus.mem_we = we; bus.data_in = d;
        @(posedge clk); #1;
        bus.ld_mar = 1'b0; bus.mem_en = 1'b0;
        n = 1;
        while (!bus.mem_rdy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 16'(n), 16'(1 + WS));
        chk("err", {15'h0, bus.mem_err}, {15'h0, oob});
        if (!we) begin
            exp = oob ? 16'h0 : mm ? mmio_read(ea) : mem_m[ea[9:0]];
            chk("rdata", bus.data_out, exp);
            last_rd = exp;
            if (ea == 16'hFE02 && mm) kb_ready_m = 1'b0;
        end else begin
            chk("wr_hold", bus.data_out, last_rd);
            if (!oob && !mm) mem_m[ea[9:0]] = d;
`ifdef LC3_MMIO_EN
            if (ea == 16'hFE06) begin
                chk("disp_strobe", {15'h0, disp_strobe}, 16'h1);
                chk("disp_data", {8'h0, disp_data}, {8'h0, d[7:0]});
            end
`endif
        end
        chk("mar", bus.mar, mar_m);
        @(posedge clk); #1;
        chk("rdy_pulse", {15'h0, bus.mem_rdy}, 16'h0);
        chk("data_hold", bus.data_out, last_rd);
    endtask

    function automatic logic [15:0] pick_addr();
        int k = $urandom_range(0, 3);
        return k == 0 ? 16'($urandom_range(0, 15)) : k == 1 ? 16'($urandom_range(1008, 1023)) :
               k == 2 ? 16'($urandom_range(1024, 1039)) : 16'hFFFF;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrdy;
        bus.addr = '0; bus.ld_mar = 0; bus.mem_en = 0; bus.mem_we = 0; bus.data_in = '0;
        bus0.addr = '0; bus0.ld_mar = 0; bus0.mem_en = 0; bus0.mem_we = 0; bus0.data_in = '0;
        #3;
        chk("rst_rdy", {15'h0, bus.mem_rdy}, 16'h0);
        chk("rst_err", {15'h0, bus.mem_err}, 16'h0);
        chk("rst_data", bus.data_out, 16'h0);
        chk("rst_mar", bus.mar, 16'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Write then read back with two wait states.
        access(1, 1, 16'h0010, 16'hBEEF);
        access(1, 0, 16'h0010, 16'h0);

        // Out-of-range read and write; the aliasing low word stays intact.
        access(1, 1, 16'h0000, 16'h7777);
        access(1, 0, 16'h0400, 16'h0);
        access(1, 1, 16'h0400, 16'h9999);
        access(1, 0, 16'h0000, 16'h0);
        access(1, 0, 16'hFE00, 16'h0);

        // Same-cycle ld_mar + mem_en must use the new address.
        access(1, 1, 16'h0003, 16'h3333);
        access(1, 1, 16'h0005, 16'h5555);
        @(posedge clk); #1; bus.addr = 16'h0003; bus.ld_mar = 1;
        @(posedge clk); #1; bus.ld_mar = 0; mar_m = 16'h0003;
        chk("mar_load", bus.mar, 16'h0003);
        access(1, 0, 16'h0005, 16'h0);

        // mem_en during WAIT is ignored: exactly one rdy.
        @(posedge clk); #1; bus.mem_en = 1; bus.mem_we = 0;
        @(posedge clk); #1; bus.mem_en = 1;
        @(posedge clk); #1; bus.mem_en = 0;
        nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            nrdy += int'(bus.mem_rdy);
            @(posedge clk); #1;
        end
        chk("single_rdy", 16'(nrdy), 16'h1);
        chk("ignored_data", bus.data_out, 16'h5555);
        last_rd = 16'h5555;

        // Reset in the middle of a write drops it.
        access(1, 1, 16'h0020, 16'h1234);
        @(posedge clk); #1;
        bus.addr = 16'h0020; bus.ld_mar = 1; bus.mem_en = 1; bus.mem_we = 1; bus.data_in = 16'hCAFE;
        @(posedge clk); #1;
        bus.ld_mar = 0; bus.mem_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rdy", {15'h0, bus.mem_rdy}, 16'h0);
        chk("abort_err", {15'h0, bus.mem_err}, 16'h0);
        chk("abort_data", bus.data_out, 16'h0);
        chk("abort_mar", bus.mar, 16'h0);
        mar_m = '0; last_rd = '0;
        @(negedge clk); rst_n = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            nrdy += int'(bus.mem_rdy);
        end
        chk("abort_no_rdy", 16'(nrdy), 16'h0);
        access(1, 0, 16'h0020, 16'h0);

        // WAIT_STATES=0 instance: level mem_en gives rdy every second cycle.
        @(posedge clk); #1;
        bus0.addr = 16'h0000; bus0.ld_mar = 1; bus0.mem_en = 1; bus0.mem_we = 1; bus0.data_in = 16'h1111;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            chk($sformatf("z_rdy%0d", c), {15'h0, bus0.mem_rdy}, 16'(c % 2));
            chk($sformatf("z_err%0d", c), {15'h0, bus0.mem_err}, 16'h0);
            if (c == 1) begin bus0.addr = 16'h0001; bus0.data_in = 16'h2222; end
            if (c == 3) begin bus0.mem_we = 0; bus0.addr = 16'h0000; end
            if (c == 5) begin chk("z_rd0", bus0.data_out, 16'h1111); bus0.addr = 16'h0001; end
            if (c == 7) begin chk("z_rd1", bus0.data_out, 16'h2222); bus0.mem_en = 0; bus0.ld_mar = 0; end
        end

        // Randomized traffic over low, top-of-store and out-of-range addresses.
        for (int i = 0; i < 16; i++) access(1, 1, 16'(i), 16'($urandom));
        for (int i = 1008; i < 1024; i++) access(1, 1, 16'(i), 16'($urandom));
        for (int i = 0; i < 40; i++) access(1'($urandom_range(0, 3) != 0), 1'($urandom), pick_addr(), 16'($urandom));

`ifdef LC3_MMIO_EN
        @(posedge clk); #1; kb_data = 8'h41; kb_strobe = 1;
        @(posedge clk); #1; kb_strobe = 0; kb_ready_m = 1; kbdr_m = 8'h41;
        access(1, 0, 16'hFE00, 16'h0);
        access(1, 0, 16'hFE02, 16'h0);
        access(1, 0, 16'hFE00, 16'h0);
        access(1, 0, 16'hFE04, 16'h0);
        access(1, 1, 16'hFE06, 16'h005A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
